// File: rtl/keyreg_pkg.sv
// rtl/keyreg_pkg.sv - shared scancodes, FSM states and glyph table for key_entry_reg
// Purpose: constants and helpers used by key_decode and key_entry_reg.
// Contents: PS/2 set-2 scancode tables, state_t enum, BLANK glyph, op_glyph().
package keyreg_pkg;

    localparam logic [7:0] KEY_ENTER  = 8'h5A;
    localparam logic [7:0] KEY_ESCAPE = 8'h76;
    localparam logic [7:0] KEY_BREAK  = 8'hF0;

    // Digit scancodes packed so that byte i is the code for digit i.
    localparam logic [10*8-1:0] DIGIT_CODES = {
        8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
    };

    // Operator scancodes packed so that byte i is the code for operator id i+1.
    localparam logic [13*8-1:0] OP_CODES = {
        8'h23, 8'h1B, 8'h1C, 8'h4D, 8'h44, 8'h43, 8'h3C,
        8'h35, 8'h2C, 8'h2D, 8'h24, 8'h1D, 8'h15
    };

    localparam logic [7:0] BLANK = 8'hA9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NUM   = 2'd1,
        ST_OP    = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Four-glyph operator word, already left-padded with BLANK.
    function automatic logic [31:0] op_glyph(input logic [3:0] id);
        case (id)
            4'd1:    op_glyph = 32'hA90A0D0D;
            4'd2:    op_glyph = 32'hA9A9A9A1;
            4'd3:    op_glyph = 32'hA9A2A8A3;
            4'd4:    op_glyph = 32'hA90DA0A4;
            4'd5:    op_glyph = 32'hA9051EA5;
            4'd6:    op_glyph = 32'hA90C0005;
            4'd7:    op_glyph = 32'hA90AA50D;
            4'd8:    op_glyph = 32'hA9A9A8A3;
            4'd9:    op_glyph = 32'hA9A5A8A6;
            4'd10:   op_glyph = 32'hA50AA50D;
            4'd11:   op_glyph = 32'hA9A5A8A3;
            4'd12:   op_glyph = 32'hA9A7A8A3;
            4'd13:   op_glyph = 32'hA7A5A8A3;
            default: op_glyph = {4{BLANK}};
        endcase
    endfunction

endpackage

// File: rtl/key_decode.sv
// rtl/key_decode.sv - combinational PS/2 scancode classifier
// Purpose: classify one scancode as digit, operator, Enter, Escape or Break.
// Ports: key_code in; is_digit/digit, is_op/op_id, is_enter, is_escape, is_break out.
module key_decode
    import keyreg_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [7:0]      key_code,
    output logic            is_digit,
    output logic [3:0]      digit,
    output logic            is_op,
    output logic [OP_W-1:0] op_id,
    output logic            is_enter,
    output logic            is_escape,
    output logic            is_break
);

    always_comb begin
        is_digit  = 1'b0;
        digit     = 4'd0;
        is_op     = 1'b0;
        op_id     = '0;
        is_enter  = (key_code == KEY_ENTER);
        is_escape = (key_code == KEY_ESCAPE);
        is_break  = (key_code == KEY_BREAK);
        for (int i = 0; i < 10; i++) begin
            if (key_code == DIGIT_CODES[i*8 +: 8]) begin
                is_digit = 1'b1;
                digit    = 4'(i);
            end
        end
        for (int i = 0; i < 13; i++) begin
            if (key_code == OP_CODES[i*8 +: 8]) begin
                is_op = 1'b1;
                op_id = OP_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/key_entry_reg.sv
// rtl/key_entry_reg.sv - keyboard entry register: BCD operand, operator, display, memory write
// Purpose: accumulate a DIGITS-digit BCD operand and operator from PS/2 key strobes,
//          drive the glyph word and hand {op_id, operand_bcd} to memory by wr/ack.
// Ports: clk, rst (sync, active-high), key_valid/key_code in, mem_ack in;
//        mem_wr, mem_data, operand_bcd, op_id, disp, overflow, key_drop out.
// Option: KEYREG_REPEAT_FILTER_EN enables the typematic repeat filter.
module key_entry_reg
    import keyreg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OP_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    input  logic [7:0]               key_code,
    input  logic                     mem_ack,
    output logic                     mem_wr,
    output logic [OP_W+4*DIGITS-1:0] mem_data,
    output logic [4*DIGITS-1:0]      operand_bcd,
    output logic [OP_W-1:0]          op_id,
    output logic [8*DIGITS-1:0]      disp,
    output logic                     overflow,
    output logic                     key_drop
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    state_t                state, state_n;
    logic [CNT_W-1:0]      count, count_n;
    logic [4*DIGITS-1:0]   operand_n;
    logic [OP_W-1:0]       op_n;
    logic                  overflow_n, key_drop_n;
    logic [8*DIGITS-1:0]   disp_n;
    logic                  accept;

    logic                  is_digit, is_op, is_enter, is_escape, is_break;
    logic [3:0]            digit;
    logic [OP_W-1:0]       dec_op;

    key_decode #(.OP_W(OP_W)) u_decode (
        .key_code  (key_code),
        .is_digit  (is_digit),
        .digit     (digit),
        .is_op     (is_op),
        .op_id     (dec_op),
        .is_enter  (is_enter),
        .is_escape (is_escape),
        .is_break  (is_break)
    );

`ifdef KEYREG_REPEAT_FILTER_EN
    logic [7:0] last_code;
    logic       last_valid;

    // A held key re-sends its make code; only the first one counts until Break.
    assign accept = key_valid && !is_break && !(last_valid && key_code == last_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_code  <= 8'h00;
            last_valid <= 1'b0;
        end else if (key_valid && is_break) begin
            last_valid <= 1'b0;
        end else if (accept) begin
            last_code  <= key_code;
            last_valid <= 1'b1;
        end
    end
`else
    assign accept = key_valid && !is_break;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            operand_bcd <= '0;
            op_id       <= '0;
            overflow    <= 1'b0;
            key_drop    <= 1'b0;
            mem_wr      <= 1'b0;
            disp        <= {DIGITS{BLANK}};
        end else begin
            state       <= state_n;
            count       <= count_n;
            operand_bcd <= operand_n;
            op_id       <= op_n;
            overflow    <= overflow_n;
            key_drop    <= key_drop_n;
            mem_wr      <= (state_n == ST_WRITE);
            disp        <= disp_n;
        end
    end

    assign mem_data = {op_id, operand_bcd};

    always_comb begin
        state_n    = state;
        count_n    = count;
        operand_n  = operand_bcd;
        op_n       = op_id;
        overflow_n = overflow;
        key_drop_n = 1'b0;

        if (state == ST_WRITE) begin
            // Ack wins over a simultaneous Escape; both end in a cleared IDLE.
            if (mem_ack || (accept && is_escape)) begin
                state_n    = ST_IDLE;
                count_n    = '0;
                operand_n  = '0;
                op_n       = '0;
                overflow_n = 1'b0;
            end
            if (accept && !is_escape) begin
                key_drop_n = 1'b1;
            end
        end else if (accept) begin
            if (is_escape) begin
                state_n    = ST_IDLE;
                count_n    = '0;
                operand_n  = '0;
                op_n       = '0;
                overflow_n = 1'b0;
            end else if (is_digit && state != ST_OP) begin
                if (count == CNT_W'(DIGITS)) begin
                    overflow_n = 1'b1;
                end else begin
                    operand_n = {operand_bcd[4*DIGITS-5:0], digit};
                    count_n   = count + 1'b1;
                    state_n   = ST_NUM;
                end
            end else if (is_op && state != ST_IDLE) begin
                op_n    = dec_op;
                state_n = ST_OP;
            end else if (is_enter && state != ST_IDLE) begin
                state_n = ST_WRITE;
            end
        end
    end

    // Display is built from next-state values so it lands with the key's edge.
    always_comb begin
        disp_n = {DIGITS{BLANK}};
        if (state_n == ST_NUM) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (CNT_W'(i) < count_n) begin
                    disp_n[8*i +: 8] = {4'h0, operand_n[4*i +: 4]};
                end
            end
        end else if (state_n == ST_OP) begin
            disp_n[31:0] = op_glyph(4'(op_n));
        end
    end

endmodule

// File: tb/tb_key_entry_reg.sv
// tb/tb_key_entry_reg.sv - directed self-checking bench for key_entry_reg
module tb_key_entry_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        mem_ack;
    logic        mem_wr;
    logic [19:0] mem_data;
    logic [15:0] operand_bcd;
    logic [3:0]  op_id;
    logic [31:0] disp;
    logic        overflow;
    logic        key_drop;

    int errors = 0;
    int checks = 0;
    int wr_cycles;

    key_entry_reg #(.DIGITS(4), .OP_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .mem_ack     (mem_ack),
        .mem_wr      (mem_wr),
        .mem_data    (mem_data),
        .operand_bcd (operand_bcd),
        .op_id       (op_id),
        .disp        (disp),
        .overflow    (overflow),
        .key_drop    (key_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle strobe; returns at the negedge after the sampling edge.
    task automatic key(input logic [7:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ack   = 1'b0;
        key_valid = 1'b1;
        key_code  = 8'h16;
        repeat (3) @(negedge clk);
        check("rst_operand", 64'(operand_bcd), 64'h0);
        key_valid = 1'b0;
        rst       = 1'b0;
        check("rst_disp", 64'(disp), 64'hA9A9A9A9);
        check("rst_mem_wr", 64'(mem_wr), 64'h0);
        check("rst_mem_data", 64'(mem_data), 64'h0);
        check("rst_op", 64'(op_id), 64'h0);
        check("rst_ovf", 64'(overflow), 64'h0);
        check("rst_drop", 64'(key_drop), 64'h0);

        // 1: three digits
        key(8'h16); key(8'h1E); key(8'h26);
        check("t1_operand", 64'(operand_bcd), 64'h0123);
        check("t1_disp", 64'(disp), 64'hA9010203);

        // 2: five digits overflow, then Escape
        key(8'h76);
        key(8'h16); key(8'h1E); key(8'h26); key(8'h25);
        check("t2_no_ovf_yet", 64'(overflow), 64'h0);
        check("t2_disp4", 64'(disp), 64'h01020304);
        key(8'h2E);
        check("t2_operand", 64'(operand_bcd), 64'h1234);
        check("t2_ovf", 64'(overflow), 64'h1);
        key(8'h76);
        check("t2_esc_operand", 64'(operand_bcd), 64'h0);
        check("t2_esc_ovf", 64'(overflow), 64'h0);
        check("t2_esc_disp", 64'(disp), 64'hA9A9A9A9);

        // 3: 7, op 1, Enter, ack two cycles after mem_wr rises
        key(8'h3D); key(8'h15);
        check("t3_op_disp", 64'(disp), 64'hA90A0D0D);
        key(8'h16);
        check("t3_digit_in_op", 64'(operand_bcd), 64'h0007);
        key(8'h5A);
        check("t3_mem_data", 64'(mem_data), 64'h10007);
        check("t3_write_disp", 64'(disp), 64'hA9A9A9A9);
        wr_cycles = 0;
        for (int i = 0; i < 10 && mem_wr; i++) begin
            wr_cycles++;
            if (wr_cycles == 3) mem_ack = 1'b1;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("t3_wr_cycles", 64'(wr_cycles), 64'd3);
        check("t3_done_mem_wr", 64'(mem_wr), 64'h0);
        check("t3_done_op", 64'(op_id), 64'h0);
        check("t3_done_operand", 64'(operand_bcd), 64'h0);

        // 4: operator in IDLE ignored; later operator replaces earlier
        key(8'h24);
        check("t4_idle_op", 64'(op_id), 64'h0);
        check("t4_idle_disp", 64'(disp), 64'hA9A9A9A9);
        key(8'h3D); key(8'h15); key(8'h1D);
        check("t4_op", 64'(op_id), 64'h2);
        check("t4_disp", 64'(disp), 64'hA9A9A9A1);
        key(8'h76);

        // 5: key dropped during WRITE, then Escape aborts the write
        key(8'h16); key(8'h5A);
        check("t5_mem_wr", 64'(mem_wr), 64'h1);
        key(8'h16);
        check("t5_drop", 64'(key_drop), 64'h1);
        check("t5_operand", 64'(operand_bcd), 64'h0001);
        check("t5_still_wr", 64'(mem_wr), 64'h1);
        @(negedge clk);
        check("t5_drop_pulse", 64'(key_drop), 64'h0);
        key(8'h76);
        check("t5_esc_mem_wr", 64'(mem_wr), 64'h0);
        check("t5_esc_operand", 64'(operand_bcd), 64'h0);

        // 6: typematic repeat and Break
        key(8'h16); key(8'h16); key(8'hF0); key(8'h16);
`ifdef KEYREG_REPEAT_FILTER_EN
        check("t6_operand", 64'(operand_bcd), 64'h0011);
`else
        check("t6_operand", 64'(operand_bcd), 64'h0111);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_entry_reg.md
# key_entry_reg

Parametrised keyboard entry register for the PS/2 calculator path. It consumes one-cycle make-code strobes from the keyboard receiver and accumulates a BCD operand of `DIGITS` digits. It captures one of 13 operator codes, drives the 7-segment glyph word, and hands the finished `{operator, operand}` record to operand memory over a write/acknowledge handshake. It sits between the PS/2 receiver and the memory/display units.

## Interface
- `DIGITS`, 4: operand length in BCD digits; must be ≥ 4 so that operator text fits.
- `OP_W`, 4: operator-id width; ids are 1..13 and 0 means "none".
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid in that cycle.
- `key_code`  in  8  PS/2 set-2 scancode.
- `mem_ack`  in  1  memory accepted the record.
- `mem_wr`  out  1  write request; held until acknowledged.
- `mem_data`  out  OP_W+4·DIGITS  `{op_id, operand_bcd}`; stable while `mem_wr` is high.
- `operand_bcd`  out  4·DIGITS  entered digits, right-justified.
- `op_id`  out  OP_W  latched operator id.
- `disp`  out  8·DIGITS  glyph word, most-significant glyph on the left.
- `overflow`  out  1  sticky: a digit was entered past `DIGITS`.
- `key_drop`  out  1  one-cycle pulse when a key is discarded during WRITE.

## Operation
- **States:**
  - IDLE: empty.
  - NUM: one or more digits entered.
  - OP: operator latched.
  - WRITE: `mem_wr` high.
- **Key classes:**
  - digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 → 0..9.
  - operators 0x15,0x1D,0x24,0x2D,0x2C,0x35,0x3C,0x43,0x44,0x4D,0x1C,0x1B,0x23 → ids 1..13.
  - Enter 0x5A; Escape 0x76; Break 0xF0.
  - Any other code is ignored.
- **Digit:**
  - In IDLE or NUM: `operand_bcd <= {operand_bcd[4·DIGITS-5:0], d}`, count+1, go to NUM.
  - At count = DIGITS the digit is ignored and `overflow` is set to 1.
  - In OP: the digit is ignored, because one operand per record.
- **Operator:**
  - In NUM or OP: latch the id (a later operator replaces an earlier one) and go to OP.
  - In IDLE: ignored.
- **Enter:** in NUM or OP, go to WRITE and assert `mem_wr`. In IDLE, ignored.
- **Escape:** from any state, including WRITE, go to IDLE. This clears operand, count, `op_id` and `overflow`, and drops `mem_wr`.
- **WRITE completion:** `mem_ack` sampled high → IDLE, with operand, `op_id`, count and `overflow` cleared.
- **Keys during WRITE:** any key other than Escape is discarded and `key_drop` pulses.
- **Ack and Escape in the same cycle:** the write counts as complete; the next state is IDLE either way.
- **Display:**
  - In NUM: digit glyph `{4'h0,d}` per entered digit, blank 8'hA9 elsewhere, right-justified.
  - In OP: the operator word, right-justified and left-padded with 8'hA9. The words are: 1 A90A0D0D, 2 A9A9A9A1, 3 A9A2A8A3, 4 A90DA0A4, 5 A9051EA5, 6 A90C0005, 7 A90AA50D, 8 A9A9A8A3, 9 A9A5A8A6, 10 A50AA50D, 11 A9A5A8A3, 12 A9A7A8A3, 13 A7A5A8A3.
  - In IDLE and WRITE: all 8'hA9.

## Timing
- All outputs are registered. A key strobed in cycle n is reflected in the outputs at edge n+1.
- `mem_wr` rises at the edge after Enter is sampled.
  - It falls at the edge after `mem_ack` is sampled high, or after Escape is sampled.
  - `mem_ack` while `mem_wr` is low is ignored.
- Minimum transaction: Enter at n, `mem_wr` high from n+1, `mem_ack` at n+1, IDLE and `mem_wr` low at n+2.
- Reset values (reset overrides every input in the same cycle):
  - state IDLE.
  - `mem_wr`, `mem_data`, `operand_bcd`, `op_id`, `overflow` and `key_drop` are 0.
  - `disp` is all 8'hA9.
  - repeat-filter memory is cleared.

## Configuration
- With `KEYREG_REPEAT_FILTER_EN` defined:
  - A strobe whose code equals the last accepted code is ignored (typematic repeat).
  - A Break 0xF0 strobe clears the remembered code, so the next key is accepted even if it has the same value.
  - Break itself is never treated as a key.
- Without the macro: every strobe is processed. Break is still ignored as a key.

## Structure
- Package `keyreg_pkg` holds:
  - the scancode localparams;
  - the state enum;
  - the 13-entry operator glyph table;
  - the `BLANK` = 8'hA9 constant.
- Sub-module `key_decode` (combinational) maps `key_code` to `{is_digit, digit[3:0], is_op, op_id, is_enter, is_escape, is_break}`.
- The top level holds the FSM, the shift register, the filter and the display mux.

## Test plan
1. Reset, then keys 0x16, 0x1E, 0x26 → `operand_bcd`=16'h0123, `disp`=32'hA9010203, state NUM.
2. Keys 1,2,3,4,5 → `operand_bcd`=16'h1234, `overflow`=1. Then Escape → everything cleared, `disp`=32'hA9A9A9A9.
3. Keys 0x3D, 0x15, 0x5A, with `mem_ack` two cycles after `mem_wr` rises → `mem_data`={4'd1,16'h0007}, `mem_wr` high for 3 cycles, then IDLE.
4. 0x24 in IDLE → ignored. Then 7, 0x15, 0x1D → `op_id`=2, `disp`=32'hA9A9A9A1.
5. Escape during WRITE with no ack → `mem_wr` low at the next edge. A key 0x16 during WRITE → `key_drop` pulse, operand unchanged.
6. 0x16, 0x16, 0xF0, 0x16 → with the macro `operand_bcd`=16'h0011; without it 16'h0111.
